// File: rtl/mont_modexp_ctrl.sv
// Modular exponentiation sequencer: result = base^exponent mod modulus.
// Left-to-right square-and-multiply over one shared Montgomery multiplier.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start_p_i, operands not yet latched
// CONV_B   | base * R^2 -> base_m (base into Montgomery domain)
// CONV_1   | 1 * R^2 -> acc (R mod m, Montgomery form of 1)
// SQR      | acc * acc -> acc, one per scanned exponent bit
// MUL      | acc * base_m -> acc, only for exponent bits that are 1
// CONV_OUT | acc * 1 -> result (back out of Montgomery domain)
// DONE     | one-cycle done pulse, busy low, then IDLE
module mont_modexp_ctrl #(
   parameter int NBITS     = 2048,
   parameter int LOG2NBITS = $clog2(NBITS),
   parameter int EBITS     = NBITS,
   parameter int LOG2EBITS = $clog2(EBITS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_p_i,
   input  logic [NBITS-1:0]     base_i,
   input  logic [EBITS-1:0]     exponent_i,
   input  logic [NBITS-1:0]     modulus_i,
   input  logic [NBITS-1:0]     r2_mod_i,
   input  logic [LOG2NBITS:0]   m_size_i,
   input  logic [LOG2EBITS:0]   e_size_i,
   output logic [NBITS-1:0]     result_o,
   output logic                 busy_o,
   output logic                 done_p_o,
   output logic                 mm_enable_p_o,
   output logic [NBITS-1:0]     mm_a_o,
   output logic [NBITS-1:0]     mm_b_o,
   output logic [NBITS-1:0]     mm_m_o,
   output logic [LOG2NBITS:0]   mm_m_size_o,
   input  logic [NBITS-1:0]     mm_y_i,
   input  logic                 mm_done_p_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_CONV_B, S_CONV_1, S_SQR, S_MUL, S_CONV_OUT, S_DONE
   } state_t;

   localparam logic [NBITS-1:0]   ONE_N = NBITS'(1);
   localparam logic [EBITS-1:0]   ONE_E = EBITS'(1);
   localparam logic [LOG2EBITS:0] ONE_I = (LOG2EBITS+1)'(1);

   state_t               state_q, state_d;
   logic [NBITS-1:0]     base_q, base_d, mod_q, mod_d, r2_q, r2_d;
   logic [EBITS-1:0]     exp_q, exp_d;
   logic [LOG2NBITS:0]   msize_q, msize_d;
   logic [LOG2EBITS:0]   esize_q, esize_d, bit_idx_q, bit_idx_d;
   logic [NBITS-1:0]     acc_q, acc_d, base_m_q, base_m_d;
   logic [NBITS-1:0]     result_d, mm_a_d, mm_b_d, mm_m_d;
   logic [LOG2NBITS:0]   mm_m_size_d;
   logic                 launch, exp_bit;

   // Next-state, capture of mm_y and operand selection for the next multiply.
   // Operands are built from the _d values so a multiply launched on the
   // same edge that captures the previous result sees the fresh value.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      exp_d       = exp_q;
      mod_d       = mod_q;
      r2_d        = r2_q;
      msize_d     = msize_q;
      esize_d     = esize_q;
      acc_d       = acc_q;
      base_m_d    = base_m_q;
      bit_idx_d   = bit_idx_q;
      result_d    = result_o;
      mm_a_d      = mm_a_o;
      mm_b_d      = mm_b_o;
      mm_m_d      = mm_m_o;
      mm_m_size_d = mm_m_size_o;
      launch      = 1'b0;
      exp_bit     = |(exp_q & (ONE_E << bit_idx_q));

      case (state_q)
         S_IDLE: begin
            if (start_p_i) begin
               base_d  = base_i;
               exp_d   = exponent_i;
               mod_d   = modulus_i;
               r2_d    = r2_mod_i;
               msize_d = m_size_i;
               esize_d = e_size_i;
               state_d = S_CONV_B;
               launch  = 1'b1;
            end
         end
         S_CONV_B: begin
            if (mm_done_p_i) begin
               base_m_d = mm_y_i;
               state_d  = S_CONV_1;
               launch   = 1'b1;
            end
         end
         S_CONV_1: begin
            if (mm_done_p_i) begin
               acc_d  = mm_y_i;
               launch = 1'b1;
               if (esize_q == '0) begin
                  bit_idx_d = '0;
                  state_d   = S_CONV_OUT;
               end else begin
                  bit_idx_d = esize_q - ONE_I;
                  state_d   = S_SQR;
               end
            end
         end
         S_SQR: begin
            if (mm_done_p_i) begin
               acc_d  = mm_y_i;
               launch = 1'b1;
               if (exp_bit) begin
                  state_d = S_MUL;
               end else if (bit_idx_q == '0) begin
                  state_d = S_CONV_OUT;
               end else begin
                  bit_idx_d = bit_idx_q - ONE_I;
                  state_d   = S_SQR;
               end
            end
         end
         S_MUL: begin
            if (mm_done_p_i) begin
               acc_d  = mm_y_i;
               launch = 1'b1;
               if (bit_idx_q == '0) begin
                  state_d = S_CONV_OUT;
               end else begin
                  bit_idx_d = bit_idx_q - ONE_I;
                  state_d   = S_SQR;
               end
            end
         end
         S_CONV_OUT: begin
            if (mm_done_p_i) begin
               result_d = mm_y_i;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         mm_m_d      = mod_d;
         mm_m_size_d = msize_d;
         case (state_d)
            S_CONV_B:   begin mm_a_d = base_d; mm_b_d = r2_d;     end
            S_CONV_1:   begin mm_a_d = ONE_N;  mm_b_d = r2_d;     end
            S_SQR:      begin mm_a_d = acc_d;  mm_b_d = acc_d;    end
            S_MUL:      begin mm_a_d = acc_d;  mm_b_d = base_m_d; end
            S_CONV_OUT: begin mm_a_d = acc_d;  mm_b_d = ONE_N;    end
            default:    begin mm_a_d = mm_a_o; mm_b_d = mm_b_o;   end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Latched job, working registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q        <= '0;
         exp_q         <= '0;
         mod_q         <= '0;
         r2_q          <= '0;
         msize_q       <= '0;
         esize_q       <= '0;
         acc_q         <= '0;
         base_m_q      <= '0;
         bit_idx_q     <= '0;
         result_o      <= '0;
         busy_o        <= 1'b0;
         done_p_o      <= 1'b0;
         mm_enable_p_o <= 1'b0;
         mm_a_o        <= '0;
         mm_b_o        <= '0;
         mm_m_o        <= '0;
         mm_m_size_o   <= '0;
      end else begin
         base_q        <= base_d;
         exp_q         <= exp_d;
         mod_q         <= mod_d;
         r2_q          <= r2_d;
         msize_q       <= msize_d;
         esize_q       <= esize_d;
         acc_q         <= acc_d;
         base_m_q      <= base_m_d;
         bit_idx_q     <= bit_idx_d;
         result_o      <= result_d;
         busy_o        <= (state_d != S_IDLE) && (state_d != S_DONE);
         done_p_o      <= (state_d == S_DONE);
         mm_enable_p_o <= launch;
         mm_a_o        <= mm_a_d;
         mm_b_o        <= mm_b_d;
         mm_m_o        <= mm_m_d;
         mm_m_size_o   <= mm_m_size_d;
      end
   end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl with NBITS=EBITS=8 and a behavioural
// Montgomery multiplier with random 5..40 cycle latency.
module tb_mont_modexp_ctrl;

   localparam int NB = 8;
   localparam int EB = 8;

   logic          clk, rst_n, start_p;
   logic [NB-1:0] base, modulus, r2_mod, result, mm_a, mm_b, mm_m, mm_y;
   logic [EB-1:0] exponent;
   logic [3:0]    m_size, e_size, mm_m_size;
   logic          busy, done_p, mm_enable_p, mm_done_p;

   int compared   = 0;
   int mismatched = 0;
   int exp_res_q[$];
   int exp_pul_q[$];
   int done_cnt = 0;
   int en_cnt   = 0;
   int last_res = 0;

   mont_modexp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
      .clk(clk), .rst_n(rst_n), .start_p_i(start_p),
      .base_i(base), .exponent_i(exponent), .modulus_i(modulus),
      .r2_mod_i(r2_mod), .m_size_i(m_size), .e_size_i(e_size),
      .result_o(result), .busy_o(busy), .done_p_o(done_p),
      .mm_enable_p_o(mm_enable_p), .mm_a_o(mm_a), .mm_b_o(mm_b),
      .mm_m_o(mm_m), .mm_m_size_o(mm_m_size),
      .mm_y_i(mm_y), .mm_done_p_i(mm_done_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // y such that y * 2^k == a*b (mod m)
   function automatic int mont(input int a, input int b, input int m, input int k);
      int t;
      t = (a * b) % m;
      for (int y = 0; y < m; y++)
         if (((y << k) % m) == t) return y;
      return 0;
   endfunction

   function automatic int modexp(input int b, input int e, input int m);
      int r;
      r = 1 % m;
      for (int i = 0; i < e; i++) r = (r * b) % m;
      return r;
   endfunction

   function automatic int popcount(input int v);
      int c;
      c = 0;
      for (int i = 0; i < 32; i++) c += (v >> i) & 1;
      return c;
   endfunction

   // Behavioural multiplier; also checks operand stability per multiply.
   initial begin : mm_model
      bit busy_m;
      int a_l, b_l, m_l, k_l, cnt;
      bit stable;
      busy_m = 0; mm_done_p = 1'b0; mm_y = '0;
      forever begin
         @(negedge clk);
         mm_done_p = 1'b0;
         if (!rst_n) begin
            busy_m = 0;
         end else if (mm_enable_p) begin
            if (busy_m) check("mm_overlap", 1, 0);
            busy_m = 1; stable = 1;
            a_l = int'(mm_a); b_l = int'(mm_b); m_l = int'(mm_m); k_l = int'(mm_m_size);
            cnt = $urandom_range(5, 40);
         end else if (busy_m) begin
            if (int'(mm_b) != b_l || int'(mm_m) != m_l || int'(mm_m_size) != k_l) stable = 0;
            cnt--;
            if (cnt == 0) begin
               mm_y = NB'(mont(a_l, b_l, m_l, k_l));
               mm_done_p = 1'b1;
               busy_m = 0;
               check("mm_operands_stable", 32'(stable), 1);
            end
         end else if ($urandom_range(0, 7) == 0) begin
            mm_y = NB'($urandom);
            mm_done_p = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on each done pulse.
   initial begin : monitor
      int r, p;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            en_cnt = 0;
         end else begin
            if (mm_enable_p) en_cnt++;
            if (done_p) begin
               if (exp_res_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  r = exp_res_q.pop_front();
                  p = exp_pul_q.pop_front();
                  check("result", 32'(result), 32'(r));
                  check("mm_pulses", 32'(en_cnt), 32'(p));
                  check("busy_in_done", 32'(busy), 0);
               end
               en_cnt = 0;
               done_cnt++;
            end
         end
      end
   end

   task automatic drive(input int b, input int e, input int m, input int r2, input int k, input int es);
      base = NB'(b); exponent = EB'(e); modulus = NB'(m);
      r2_mod = NB'(r2); m_size = 4'(k); e_size = 4'(es);
   endtask

   task automatic start_job(input int b, input int e, input int m, input int r2, input int k, input int es);
      int em;
      em = (es >= 8) ? e : (e & ((1 << es) - 1));
      drive(b, e, m, r2, k, es);
      start_p = 1'b1;
      last_res = modexp(b, em, m);
      exp_res_q.push_back(last_res);
      exp_pul_q.push_back(3 + es + popcount(em));
      @(negedge clk);
      start_p = 1'b0;
      check("busy_after_start", 32'(busy), 1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 4000 && done_cnt < target; i++) @(negedge clk);
      check("done_reached", 32'(done_cnt), 32'(target));
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_result"}, 32'(result), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done_p), 0);
      check({tag, "_mm_en"}, 32'(mm_enable_p), 0);
      check({tag, "_mm_a"}, 32'(mm_a), 0);
      check({tag, "_mm_b"}, 32'(mm_b), 0);
      check({tag, "_mm_m"}, 32'(mm_m), 0);
      check({tag, "_mm_msize"}, 32'(mm_m_size), 0);
   endtask

   initial begin : stimulus
      int m, k, t;
      rst_n = 1'b0; start_p = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed jobs, modulus 13, R = 32, R^2 mod 13 = 10
      start_job(7, 5, 13, 10, 5, 3);     wait_done(1);
      repeat (5) @(negedge clk);
      check("result_held", 32'(result), 32'(last_res));
      check("idle_busy", 32'(busy), 0);
      start_job(7, 0, 13, 10, 5, 3);     wait_done(2);
      start_job(9, 8'hA5, 13, 10, 5, 0); wait_done(3);
      start_job(2, 8'hFF, 13, 10, 5, 8); wait_done(4);

      // start_p pulses while busy (incl. SQR) and in the DONE cycle
      start_job(7, 5, 13, 10, 5, 3);
      for (int i = 0; i < 4000 && done_cnt < 5; i++) begin
         if (busy && (en_cnt == 3 || $urandom_range(0, 3) == 0)) begin
            drive($urandom_range(0, 255), $urandom_range(0, 255), 255, 1, 8, 8);
            start_p = 1'b1;
         end else if (done_p) begin
            start_p = 1'b1;
         end else begin
            start_p = 1'b0;
         end
         @(negedge clk);
      end
      start_p = 1'b0;
      check("done_reached_dist", 32'(done_cnt), 5);
      repeat (4) @(negedge clk);
      check("ignored_start_busy", 32'(busy), 0);
      check("ignored_start_result", 32'(result), 32'(last_res));

      // Reset while in MUL (4th multiply of this job)
      start_job(7, 5, 13, 10, 5, 3);
      for (int i = 0; i < 2000 && en_cnt < 4; i++) @(negedge clk);
      check("reached_mul", 32'(en_cnt), 4);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      exp_res_q.delete();
      exp_pul_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("no_done_after_abort", 32'(done_cnt), 5);
      start_job(7, 5, 13, 10, 5, 3);     wait_done(6);

      // Random jobs
      for (int j = 0; j < 12; j++) begin
         m = 2 * $urandom_range(1, 127) + 1;
         k = 0;
         while ((1 << k) <= m) k++;
         t = done_cnt + 1;
         start_job($urandom_range(0, m - 1), $urandom_range(0, 255), m,
                   (1 << (2 * k)) % m, k, $urandom_range(0, 8));
         wait_done(t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
